// File: rtl/es_driver.sv
// es_driver: issues push/pop/dup commands to an expression stack,
// checks each one against the tracked occupancy, and reports completion
// or an overflow/underflow rejection with one-cycle pulses.
module es_driver #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [1:0]  reqOp,
    input  logic [15:0] reqVal,
    input  logic [1:0]  reqCnt,
    output logic [1:0]  ESOp,
    output logic        ESAct,
    output logic [15:0] pushVal,
    output logic        popNum,
    output logic [1:0]  dupNum,
    output logic [5:0]  depth,
    output logic        done,
    output logic        errOvf,
    output logic        errUnf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_DUP  = 2'd2;

    // Capacity widened by one bit so depth+count never wraps in the compare.
    localparam logic [6:0] CAP = 7'(DEPTH);

    state_t      state_q, state_d;
    logic [5:0]  depth_q, depth_d;

    // Command captured at accept; used while the command is in flight.
    logic [1:0]  cmdOp_q;
    logic [15:0] cmdVal_q;
    logic [1:0]  cmdCnt_q;

    // Last values presented to the stack, held while not issuing.
    logic [1:0]  holdOp_q;
    logic [15:0] holdVal_q;
    logic [1:0]  holdCnt_q;

    logic        errOvf_q;
    logic        errUnf_q;

    logic        accept;
    logic        isOvf;
    logic        isUnf;
    logic        legal;
    logic [6:0]  curDepth;
    logic [6:0]  need;

    assign reqReady = (state_q == IDLE);
    assign accept   = reqValid & reqReady;
    assign legal    = ~isOvf & ~isUnf;

    // Classify the incoming request against the current occupancy;
    // underflow is checked before overflow for dup.
    always_comb begin
        curDepth = {1'b0, depth_q};
        need     = {5'd0, reqCnt} + 7'd1;
        isOvf    = 1'b0;
        isUnf    = 1'b0;
        case (reqOp)
            OP_PUSH: begin
                isOvf = (curDepth >= CAP);
            end
            OP_POP: begin
                if (reqCnt >= 2'd2) begin
                    isUnf = 1'b1;
                end else if (curDepth < need) begin
                    isUnf = 1'b1;
                end
            end
            OP_DUP: begin
                if (curDepth < need) begin
                    isUnf = 1'b1;
                end else if ((curDepth + need) > CAP) begin
                    isOvf = 1'b1;
                end
            end
            default: begin
                isUnf = 1'b1;
            end
        endcase
    end

    // Next-state logic: only a legal accept leaves IDLE; ISSUE and SETTLE
    // each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy moves on the edge that ends ISSUE; legality was already
    // established at accept, so the result stays within 0..DEPTH.
    always_comb begin
        depth_d = depth_q;
        if (state_q == ISSUE) begin
            case (cmdOp_q)
                OP_PUSH: depth_d = depth_q + 6'd1;
                OP_POP:  depth_d = depth_q - ({4'd0, cmdCnt_q} + 6'd1);
                OP_DUP:  depth_d = depth_q + ({4'd0, cmdCnt_q} + 6'd1);
                default: depth_d = depth_q;
            endcase
        end
    end

    // State, captured command, held stack outputs, occupancy and error pulses.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            depth_q   <= 6'd0;
            cmdOp_q   <= 2'd0;
            cmdVal_q  <= 16'd0;
            cmdCnt_q  <= 2'd0;
            holdOp_q  <= 2'd0;
            holdVal_q <= 16'd0;
            holdCnt_q <= 2'd0;
            errOvf_q  <= 1'b0;
            errUnf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            errOvf_q <= accept & isOvf;
            errUnf_q <= accept & isUnf;
            if (accept) begin
                cmdOp_q  <= reqOp;
                cmdVal_q <= reqVal;
                cmdCnt_q <= reqCnt;
            end
            if (state_q == ISSUE) begin
                holdOp_q  <= cmdOp_q;
                holdVal_q <= cmdVal_q;
                holdCnt_q <= cmdCnt_q;
            end
        end
    end

    // Stack-facing outputs come straight from the captured command during
    // ISSUE and from the held copy at all other times.
    always_comb begin
        ESAct   = (state_q == ISSUE);
        ESOp    = holdOp_q;
        pushVal = holdVal_q;
        popNum  = holdCnt_q[0];
        dupNum  = holdCnt_q;
        if (state_q == ISSUE) begin
            ESOp    = cmdOp_q;
            pushVal = cmdVal_q;
            popNum  = cmdCnt_q[0];
            dupNum  = cmdCnt_q;
        end
    end

    // A reset landing in SETTLE aborts the command, so done is masked then.
    assign done   = (state_q == SETTLE) & resetN;
    assign errOvf = errOvf_q;
    assign errUnf = errUnf_q;
    assign depth  = depth_q;

endmodule

// File: doc/es_driver.md
ES_DRIVER -- requirements
Module: es_driver

Interface
REQ-001 Parameter DEPTH, default 32, meaning the expression-stack capacity in entries.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 resetN  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 reqValid  input  1  a command request is present.
REQ-005 reqReady  output  1  the block accepts a request this cycle.
REQ-006 reqOp  input  2  0=push, 1=pop, 2=dup, 3=illegal.
REQ-007 reqVal  input  16  the push value, used only when reqOp=0.
REQ-008 reqCnt  input  2  pop: 0 pops 1 entry, 1 pops 2, others illegal; dup: n duplicates the top n+1 entries.
REQ-009 ESOp  output  2  the stack operation code to the expression stack.
REQ-010 ESAct  output  1  one-cycle action strobe to the expression stack.
REQ-011 pushVal  output  16  the value to push.
REQ-012 popNum  output  1  the pop count select.
REQ-013 dupNum  output  2  the dup count select.
REQ-014 depth  output  6  current tracked stack occupancy, 0..DEPTH.
REQ-015 done  output  1  one-cycle pulse: the accepted command has completed.
REQ-016 errOvf  output  1  one-cycle pulse: the command was rejected for overflow.
REQ-017 errUnf  output  1  one-cycle pulse: the command was rejected for underflow or illegal encoding.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and SETTLE; reqReady SHALL be 1 only in IDLE.
REQ-019 Accept = reqValid & reqReady; on accept, the block SHALL register reqOp/reqVal/reqCnt and evaluate legality against the current depth.
REQ-020 Push is legal iff depth < DEPTH; otherwise overflow.
REQ-021 Pop is legal iff reqCnt <= 1 and depth >= reqCnt+1; reqCnt >= 2 is illegal.
REQ-022 Dup is legal iff depth >= reqCnt+1 and depth+reqCnt+1 <= DEPTH; a shortfall is underflow, an excess is overflow (underflow checked first).
REQ-023 reqOp=3 SHALL be illegal and report as errUnf.
REQ-024 Legal accept: IDLE->ISSUE; illegal accept: errOvf or errUnf SHALL pulse the next cycle, ESAct SHALL stay 0, the state SHALL stay IDLE, and depth SHALL be unchanged.
REQ-025 In ISSUE, ESAct=1 for exactly one cycle, with ESOp/pushVal/popNum/dupNum driven from the registered fields; then ISSUE->SETTLE.
REQ-026 Outside ISSUE, ESAct SHALL be 0; ESOp/pushVal/popNum/dupNum SHALL hold their last values.
REQ-027 depth SHALL update on the edge ending ISSUE: push +1, pop -(reqCnt+1), dup +(reqCnt+1); it never leaves 0..DEPTH.
REQ-028 In SETTLE, done=1 for one cycle (stack outputs valid); then SETTLE->IDLE.
REQ-029 Latency: accept at edge N; ESAct high cycle N+1; done high cycle N+2; next accept possible at edge N+3.
REQ-030 reqValid while not ready SHALL be ignored; the requester holds its request until accepted.
REQ-031 done, errOvf and errUnf SHALL be mutually exclusive in any cycle.

Reset
REQ-032 With resetN=0 at a rising edge: state=IDLE, ESAct=0, ESOp=0, pushVal=0, popNum=0, dupNum=0, depth=0, done=0, errOvf=0, errUnf=0, reqReady=1 the following cycle.
REQ-033 Reset asserted in ISSUE or SETTLE SHALL abort the command with no done pulse; depth SHALL be 0 even if ESAct already fired.

Verification
REQ-034 Reset, push 0x0001 -> ESAct pulses once with ESOp=0, pushVal=1; done two cycles after accept; depth=1.
REQ-035 From depth=1, pop reqCnt=0 -> ESOp=1, popNum=0, done; depth=0; second pop -> errUnf pulse, no ESAct, depth=0.
REQ-036 32 pushes of 1..32 -> depth=32; 33rd push -> errOvf, no ESAct; pop reqCnt=1 -> depth=30.
REQ-037 depth=30, dup reqCnt=1 -> ESOp=2, dupNum=1, depth=32; dup reqCnt=0 at 32 -> errOvf.
REQ-038 reqOp=3 or pop reqCnt=2 -> errUnf, depth unchanged; reqValid held during ISSUE/SETTLE -> not accepted until IDLE.
REQ-039 resetN low during SETTLE of a push at depth 5 -> no done; depth=0, reqReady=1 next cycle.
